writeback_commit: RTL and testbench

WRITEBACK_COMMIT -- requirements
Module: writeback_commit

---
 rtl/writeback_commit.sv | 182 ++++++++++++++++++
 tb/tb_writeback_commit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_commit.sv
// writeback_commit: Y86-64 style write-back / PC-update stage with a
// 15-entry register file, status tracking and a retired-instruction counter.
//
// Ports
//   clk, reset                : clock, asynchronous active-high reset
//   icode, ifun, rA, rB, cnd  : current instruction fields and branch/cmov condition
//   valE, valM, valC, valP    : ALU result, memory data, constant, next sequential PC
//   instr_valid, imemerror,
//   dmemerror                 : fetch/decode/memory status of the current instruction
//   srcA, srcB / valA, valB   : decode read ports (combinational, no write bypass)
//   PC, stat, halted, retired : architectural PC, status code, stopped flag, commit count
module writeback_commit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic        instr_valid,
    input  logic        imemerror,
    input  logic        dmemerror,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] PC,
    output logic [2:0]  stat,
    output logic        halted,
    output logic [63:0] retired
);

    localparam int unsigned W    = 64;
    localparam int unsigned NREG = 15;

    localparam logic [3:0] R_NONE = 4'hF;
    localparam logic [3:0] R_RSP  = 4'h4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_IRMOV  = 4'h3;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic {RUN, STOP} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [2:0]     stat_q, stat_d;
    logic [W-1:0]   retired_q, retired_d;
    logic [W-1:0]   regs_q [NREG];
    logic [W-1:0]   regs_d [NREG];

    logic [3:0]     dst_e;
    logic [3:0]     dst_m;
    logic [W-1:0]   new_pc;
    logic [2:0]     cls;

    // ifun only matters through cnd, which is resolved upstream
    logic           unused_ifun;
    assign unused_ifun = ^ifun;

    // Decode read ports see pre-edge register contents
    assign valA = (srcA == R_NONE) ? '0 : regs_q[srcA];
    assign valB = (srcB == R_NONE) ? '0 : regs_q[srcB];

    // Destination selection
    always_comb begin
        dst_e = R_NONE;
        dst_m = R_NONE;
        unique case (icode)
            I_CMOV:                          dst_e = cnd ? rB : R_NONE;
            I_IRMOV, I_OPQ:                  dst_e = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e = R_RSP;
            default:                         dst_e = R_NONE;
        endcase
        if (icode == I_MRMOV || icode == I_POPQ) begin
            dst_m = rA;
        end
    end

    // Next PC selection
    always_comb begin
        new_pc = valP;
        unique case (icode)
            I_CALL:  new_pc = valC;
            I_RET:   new_pc = valM;
            I_JXX:   new_pc = cnd ? valC : valP;
            default: new_pc = valP;
        endcase
    end

    // Status classification, address errors dominate
    always_comb begin
        cls = S_AOK;
        if (imemerror || dmemerror) begin
            cls = S_ADR;
        end else if (!instr_valid) begin
            cls = S_INS;
        end else if (icode == I_HALT) begin
            cls = S_HLT;
        end
    end

    // Next-state: commit in RUN/AOK, otherwise latch status and freeze
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        stat_d    = stat_q;
        retired_d = retired_q;
        for (int i = 0; i < int'(NREG); i++) begin
            regs_d[i] = regs_q[i];
        end
        case (state_q)
            RUN: begin
                if (cls == S_AOK) begin
                    if (dst_e != R_NONE) begin
                        regs_d[dst_e] = valE;
                    end
                    // Applied second so memory data wins on popq %rsp
                    if (dst_m != R_NONE) begin
                        regs_d[dst_m] = valM;
                    end
                    pc_d      = new_pc;
                    retired_d = retired_q + W'(1);
                end else begin
                    stat_d  = cls;
                    state_d = STOP;
                end
            end
            STOP: begin
                state_d = STOP;
            end
            default: begin
                state_d = STOP;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            stat_q    <= S_AOK;
            retired_q <= '0;
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign PC      = pc_q;
    assign stat    = stat_q;
    assign retired = retired_q;
    assign halted  = (state_q == STOP);

endmodule

// File: tb/tb_writeback_commit.sv
// tb_writeback_commit: directed vectors for writeback_commit. Stimulus pushes
// hand-computed expectations into a queue; a monitor drains and compares them
// one step after each rising edge, or on demand between edges.
module tb_writeback_commit;

    localparam logic [63:0] RPC = 64'h100;

    localparam int unsigned SEL_PC   = 0;
    localparam int unsigned SEL_STAT = 1;
    localparam int unsigned SEL_HALT = 2;
    localparam int unsigned SEL_RET  = 3;
    localparam int unsigned SEL_VALA = 4;
    localparam int unsigned SEL_VALB = 5;

    logic        clk;
    logic        reset;
    logic [3:0]  icode, ifun, rA, rB, srcA, srcB;
    logic        cnd, instr_valid, imemerror, dmemerror;
    logic [63:0] valE, valM, valC, valP;
    logic [63:0] valA, valB, PC, retired;
    logic [2:0]  stat;
    logic        halted;

    writeback_commit #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .cnd(cnd),
        .valE(valE), .valM(valM), .valC(valC), .valP(valP),
        .instr_valid(instr_valid), .imemerror(imemerror), .dmemerror(dmemerror),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .PC(PC), .stat(stat), .halted(halted), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int unsigned sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    event sample_ev;

    function automatic logic [63:0] observe(int unsigned sel);
        case (sel)
            SEL_PC:   return PC;
            SEL_STAT: return 64'(stat);
            SEL_HALT: return 64'(halted);
            SEL_RET:  return retired;
            SEL_VALA: return valA;
            default:  return valB;
        endcase
    endfunction

    // Monitor: compare everything queued so far
    always begin
        exp_t        e;
        logic [63:0] act;
        @(posedge clk or sample_ev);
        #1;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = observe(e.sel);
            n_checks++;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
    end

    task automatic expv(input string n, input int unsigned sel, input logic [63:0] v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic exp_state(input string tag, input logic [63:0] pc, input logic [2:0] st,
                             input logic hl, input logic [63:0] ret);
        expv({tag, ".PC"}, SEL_PC, pc);
        expv({tag, ".stat"}, SEL_STAT, 64'(st));
        expv({tag, ".halted"}, SEL_HALT, 64'(hl));
        expv({tag, ".retired"}, SEL_RET, ret);
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic c, input logic [63:0] e, input logic [63:0] m,
                         input logic [63:0] cc, input logic [63:0] p,
                         input logic iv, input logic ime, input logic dme,
                         input logic [3:0] sa, input logic [3:0] sb);
        icode = ic; ifun = 4'h0; rA = ra; rB = rb; cnd = c;
        valE = e; valM = m; valC = cc; valP = p;
        instr_valid = iv; imemerror = ime; dmemerror = dme;
        srcA = sa; srcB = sb;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 4'h2, 4'hF);
        #2;
        exp_state("reset", RPC, 3'd1, 1'b0, 64'd0);
        expv("reset.valA", SEL_VALA, 64'h0);
        -> sample_ev;
        @(negedge clk);
        reset = 1'b0;

        // irmovq $5, %rdx
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h5, 64'h0, 64'h5, 64'hA, 1'b1, 1'b0, 1'b0, 4'h2, 4'hF);
        exp_state("irmovq", 64'hA, 3'd1, 1'b0, 64'd1);
        expv("irmovq.reg2", SEL_VALA, 64'h5);
        @(posedge clk);

        // popq %rsp: valM beats valE
        @(negedge clk);
        drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h77, 64'h0, 64'hC, 1'b1, 1'b0, 1'b0, 4'h4, 4'hF);
        exp_state("popq_rsp", 64'hC, 3'd1, 1'b0, 64'd2);
        expv("popq_rsp.reg4", SEL_VALA, 64'h77);
        @(posedge clk);

        // cmovXX not taken
        @(negedge clk);
        drive(4'h2, 4'h2, 4'h3, 1'b0, 64'h5, 64'h0, 64'h0, 64'hE, 1'b1, 1'b0, 1'b0, 4'h3, 4'hF);
        exp_state("cmov_nt", 64'hE, 3'd1, 1'b0, 64'd3);
        expv("cmov_nt.reg3", SEL_VALA, 64'h0);
        @(posedge clk);

        // jXX not taken / taken
        @(negedge clk);
        drive(4'h7, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h40, 64'h19, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
        exp_state("jxx_nt", 64'h19, 3'd1, 1'b0, 64'd4);
        @(posedge clk);
        @(negedge clk);
        drive(4'h7, 4'hF, 4'hF, 1'b1, 64'h0, 64'h0, 64'h40, 64'h19, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
        exp_state("jxx_t", 64'h40, 3'd1, 1'b0, 64'd5);
        @(posedge clk);

        // call / ret
        @(negedge clk);
        drive(4'h8, 4'hF, 4'hF, 1'b0, 64'h100, 64'h0, 64'h80, 64'h49, 1'b1, 1'b0, 1'b0, 4'h4, 4'hF);
        exp_state("call", 64'h80, 3'd1, 1'b0, 64'd6);
        expv("call.rsp", SEL_VALA, 64'h100);
        @(posedge clk);
        @(negedge clk);
        drive(4'h9, 4'hF, 4'hF, 1'b0, 64'h108, 64'h49, 64'h0, 64'h81, 1'b1, 1'b0, 1'b0, 4'h4, 4'hF);
        exp_state("ret", 64'h49, 3'd1, 1'b0, 64'd7);
        expv("ret.rsp", SEL_VALA, 64'h108);
        @(posedge clk);

        // mrmovq into %rsi, then OPq into %rsi
        @(negedge clk);
        drive(4'h5, 4'h6, 4'hF, 1'b0, 64'h20, 64'hDEAD, 64'h0, 64'h53, 1'b1, 1'b0, 1'b0, 4'h6, 4'hF);
        exp_state("mrmovq", 64'h53, 3'd1, 1'b0, 64'd8);
        expv("mrmovq.reg6", SEL_VALA, 64'hDEAD);
        @(posedge clk);
        @(negedge clk);
        drive(4'h6, 4'h2, 4'h6, 1'b0, 64'hDEB2, 64'h0, 64'h0, 64'h55, 1'b1, 1'b0, 1'b0, 4'h6, 4'h2);
        exp_state("opq", 64'h55, 3'd1, 1'b0, 64'd9);
        expv("opq.reg6", SEL_VALA, 64'hDEB2);
        expv("opq.reg2", SEL_VALB, 64'h5);
        @(posedge clk);

        // nop with srcA = none
        @(negedge clk);
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h0, 64'h57, 1'b1, 1'b0, 1'b0, 4'hF, 4'h2);
        exp_state("nop", 64'h57, 3'd1, 1'b0, 64'd10);
        expv("nop.srcA_none", SEL_VALA, 64'h0);
        expv("nop.reg2", SEL_VALB, 64'h5);
        @(posedge clk);

        // mrmovq with dmemerror stops without writing
        @(negedge clk);
        drive(4'h5, 4'h2, 4'hF, 1'b0, 64'h0, 64'h99, 64'h0, 64'h60, 1'b1, 1'b0, 1'b1, 4'h2, 4'hF);
        exp_state("dmemerr", 64'h57, 3'd3, 1'b1, 64'd10);
        expv("dmemerr.reg2", SEL_VALA, 64'h5);
        @(posedge clk);

        // stopped: later AOK input ignored
        @(negedge clk);
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h7, 64'h0, 64'h7, 64'h70, 1'b1, 1'b0, 1'b0, 4'h2, 4'hF);
        exp_state("stopped", 64'h57, 3'd3, 1'b1, 64'd10);
        expv("stopped.reg2", SEL_VALA, 64'h5);
        @(posedge clk);

        // ADR beats INS and HLT
        do_reset();
        drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h0, 64'h101, 1'b0, 1'b1, 1'b0, 4'h2, 4'hF);
        exp_state("adr_prio", RPC, 3'd3, 1'b1, 64'd0);
        expv("adr_prio.reg2_cleared", SEL_VALA, 64'h0);
        @(posedge clk);

        // INS beats HLT
        do_reset();
        drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h0, 64'h101, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF);
        exp_state("ins_prio", RPC, 3'd4, 1'b1, 64'd0);
        @(posedge clk);

        // plain halt
        do_reset();
        drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 64'h0, 64'h101, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
        exp_state("halt", RPC, 3'd2, 1'b1, 64'd0);
        @(posedge clk);

        // write reg3, then reset mid-cycle during a taken cmov
        do_reset();
        drive(4'h3, 4'hF, 4'h3, 1'b0, 64'h33, 64'h0, 64'h33, 64'h10A, 1'b1, 1'b0, 1'b0, 4'h3, 4'hF);
        exp_state("pre_rst", 64'h10A, 3'd1, 1'b0, 64'd1);
        expv("pre_rst.reg3", SEL_VALA, 64'h33);
        @(posedge clk);
        @(negedge clk);
        drive(4'h2, 4'h2, 4'h3, 1'b1, 64'h55, 64'h0, 64'h0, 64'h10C, 1'b1, 1'b0, 1'b0, 4'h3, 4'hF);
        #2;
        reset = 1'b1;
        exp_state("async_rst", RPC, 3'd1, 1'b0, 64'd0);
        expv("async_rst.reg3", SEL_VALA, 64'h0);
        -> sample_ev;
        @(negedge clk);
        reset = 1'b0;

        // first edge after reset release commits
        drive(4'h3, 4'hF, 4'h3, 1'b0, 64'h9, 64'h0, 64'h9, 64'h10A, 1'b1, 1'b0, 1'b0, 4'h3, 4'hF);
        exp_state("post_rst", 64'h10A, 3'd1, 1'b0, 64'd1);
        expv("post_rst.reg3", SEL_VALA, 64'h9);
        @(posedge clk);
        #3;

        if (sb_q.size() != 0) begin
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
            n_checks++;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
